// File: rtl/aes_pkg.sv
// Shared command/state encodings and block width for the AES stream loader.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        C_ID = 2'b00,
        C_SP = 2'b01,
        C_SK = 2'b10,
        C_ST = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DRAIN = 2'b10
    } state_e;

endpackage

// File: rtl/aes_beat_packer.sv
// Assembles an OUT_W-bit word from DIN_W-bit beats, first beat in the MSBs.
module aes_beat_packer #(
    parameter int unsigned DIN_W = 8,
    parameter int unsigned OUT_W = 128
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             load,
    input  logic             clr_cnt,
    input  logic             clr_valid,
    input  logic [DIN_W-1:0] din,
    output logic [OUT_W-1:0] data,
    output logic             valid
);

    localparam int unsigned NBEATS = OUT_W / DIN_W;
    localparam int unsigned CW     = $clog2(NBEATS + 1);
    localparam logic [CW-1:0] FULL = CW'(NBEATS);
    localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst_) begin
            data  <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else begin
            if (clr_cnt) begin
                cnt <= '0;
            end else if (load && (cnt != FULL)) begin
                // Indexed write keeps a partial load MSB-aligned
                for (int unsigned b = 0; b < NBEATS; b++) begin
                    if (cnt == CW'(b))
                        data[OUT_W-1-b*DIN_W -: DIN_W] <= din;
                end
                cnt <= cnt + 1'b1;
                if (cnt == LAST)
                    valid <= 1'b1;
                else if (cnt == '0)
                    valid <= 1'b0;
            end
            if (clr_valid)
                valid <= 1'b0;
        end
    end

endmodule

// File: rtl/aes_stream_loader.sv
// AES core front-end: beat-wise plaintext/key loading, start control and
// valid/ready serialisation of the ciphertext.
module aes_stream_loader
    import aes_pkg::*;
#(
    parameter int unsigned DIN_W  = 8,
    parameter int unsigned DOUT_W = 8,
    parameter int unsigned KEY_W  = 128
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [DIN_W-1:0]       din,
    input  logic [1:0]             cmd,
    output logic                   interface_ready,
    output logic [AES_BLOCK_W-1:0] pt_out,
    output logic [KEY_W-1:0]       key_out,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic [AES_BLOCK_W-1:0] ct_in,
    output logic [DOUT_W-1:0]      dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   engine_done,
    output logic                   load_err
);

    localparam int unsigned OBEATS = AES_BLOCK_W / DOUT_W;
    localparam int unsigned OW     = $clog2(OBEATS + 1);
    localparam logic [OW-1:0] LAST_O = OW'(OBEATS - 1);

    state_e                 state, state_nxt;
    cmd_e                   cmd_c;
    logic                   in_idle;
    logic                   pt_valid, key_valid;
    logic                   start_fire, refuse, accept, last_beat;
    logic [AES_BLOCK_W-1:0] shift;
    logic [OW-1:0]          ocnt;

    assign cmd_c           = cmd_e'(cmd);
    assign in_idle         = (state == IDLE);
    assign interface_ready = in_idle;
    assign dout_valid      = (state == DRAIN);
    assign dout            = shift[AES_BLOCK_W-1 -: DOUT_W];
    assign accept          = dout_valid && dout_ready;

    // Selecting one target clears the other's counter, so switching restarts it
    aes_beat_packer #(
        .DIN_W (DIN_W),
        .OUT_W (AES_BLOCK_W)
    ) u_pt (
        .clk       (clk),
        .rst_      (rst_),
        .load      (in_idle && (cmd_c == C_SP)),
        .clr_cnt   (in_idle && ((cmd_c == C_ID) || (cmd_c == C_SK))),
        .clr_valid (start_fire),
        .din       (din),
        .data      (pt_out),
        .valid     (pt_valid)
    );

    aes_beat_packer #(
        .DIN_W (DIN_W),
        .OUT_W (KEY_W)
    ) u_key (
        .clk       (clk),
        .rst_      (rst_),
        .load      (in_idle && (cmd_c == C_SK)),
        .clr_cnt   (in_idle && ((cmd_c == C_ID) || (cmd_c == C_SP))),
        .clr_valid (1'b0),
        .din       (din),
        .data      (key_out),
        .valid     (key_valid)
    );

    always_comb begin
        state_nxt  = state;
        start_fire = 1'b0;
        refuse     = 1'b0;
        last_beat  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_c == C_ST) begin
                    if (pt_valid && key_valid) begin
                        start_fire = 1'b1;
                        state_nxt  = BUSY;
                    end else begin
                        refuse = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (core_done)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (accept && (ocnt == LAST_O)) begin
                    last_beat = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            state       <= IDLE;
            core_start  <= 1'b0;
            engine_done <= 1'b0;
            load_err    <= 1'b0;
            shift       <= '0;
            ocnt        <= '0;
        end else begin
            state       <= state_nxt;
            core_start  <= start_fire;
            engine_done <= last_beat;
            if (start_fire)
                load_err <= 1'b0;
            else if (refuse)
                load_err <= 1'b1;
            if ((state == BUSY) && core_done) begin
                shift <= ct_in;
                ocnt  <= '0;
            end else if (accept) begin
                shift <= shift << DOUT_W;
                ocnt  <= ocnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_stream_loader.sv
// Directed bench: byte-wide instance for load/start/drain/error paths,
// 32-bit/256-bit-key instance for wide beats and reset in BUSY.
module tb_aes_stream_loader;
    import aes_pkg::*;

    localparam logic [127:0] PT  = 128'h00041214120412000C00131108231919;
    localparam logic [127:0] KEY = 128'h2475A2B33475568831E2120013AA5487;
    localparam logic [127:0] CT  = 128'h3925841D02DC09FBDC118597196A0B32;
    localparam logic [127:0] PT2 = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [255:0] KEY256 =
        256'h2475A2B33475568831E2120013AA5487000102030405060708090A0B0C0D0E0F;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    // byte-wide instance
    logic [7:0]   a_din;
    logic [1:0]   a_cmd;
    logic         a_ready, a_start, a_cdone, a_dvalid, a_dready, a_edone, a_err;
    logic [127:0] a_pt, a_key, a_ct;
    logic [7:0]   a_dout;

    aes_stream_loader #(.DIN_W(8), .DOUT_W(8), .KEY_W(128)) u_a (
        .clk(clk), .rst_(rst_), .din(a_din), .cmd(a_cmd),
        .interface_ready(a_ready), .pt_out(a_pt), .key_out(a_key),
        .core_start(a_start), .core_done(a_cdone), .ct_in(a_ct),
        .dout(a_dout), .dout_valid(a_dvalid), .dout_ready(a_dready),
        .engine_done(a_edone), .load_err(a_err)
    );

    // wide instance
    logic [31:0]  b_din;
    logic [1:0]   b_cmd;
    logic         b_ready, b_start, b_cdone, b_dvalid, b_dready, b_edone, b_err;
    logic [127:0] b_pt, b_ct;
    logic [255:0] b_key;
    logic [31:0]  b_dout;

    aes_stream_loader #(.DIN_W(32), .DOUT_W(32), .KEY_W(256)) u_b (
        .clk(clk), .rst_(rst_), .din(b_din), .cmd(b_cmd),
        .interface_ready(b_ready), .pt_out(b_pt), .key_out(b_key),
        .core_start(b_start), .core_done(b_cdone), .ct_in(b_ct),
        .dout(b_dout), .dout_valid(b_dvalid), .dout_ready(b_dready),
        .engine_done(b_edone), .load_err(b_err)
    );

    typedef struct {
        logic [1:0]   cmd;
        logic [7:0]   din;
        logic [127:0] exp_pt;
        logic [127:0] exp_key;
    } vec_t;

    vec_t tv [34];
    int   vectors = 0;
    int   fails   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [1:0] c, input logic [127:0] val, input int n);
        logic [127:0] v;
        v = val;
        for (int i = 0; i < n; i++) begin
            a_cmd = c;
            a_din = v[127-8*i -: 8];
            tick();
        end
    endtask

    initial begin
        logic [127:0] ones, ct_v;
        logic [255:0] k_v;
        int starts, idx;
        logic rdy;

        rst_ = 1'b1;
        a_din = '0; a_cmd = C_ID; a_cdone = 1'b0; a_ct = CT; a_dready = 1'b0;
        b_din = '0; b_cmd = C_ID; b_cdone = 1'b0; b_ct = CT; b_dready = 1'b0;
        ones = '1;
        ct_v = CT;
        k_v  = KEY256;

        for (int i = 0; i < 16; i++) begin
            tv[i].cmd     = C_SP;
            tv[i].din     = PT[127-8*i -: 8];
            tv[i].exp_pt  = PT & ~(ones >> (8*(i+1)));
            tv[i].exp_key = '0;
        end
        tv[16] = '{cmd: C_ID, din: 8'h00, exp_pt: PT, exp_key: '0};
        for (int i = 0; i < 16; i++) begin
            tv[17+i].cmd     = C_SK;
            tv[17+i].din     = KEY[127-8*i -: 8];
            tv[17+i].exp_pt  = PT;
            tv[17+i].exp_key = KEY & ~(ones >> (8*(i+1)));
        end
        tv[33] = '{cmd: C_SK, din: 8'hFF, exp_pt: PT, exp_key: KEY};

        tick(); tick();
        rst_ = 1'b0;
        chk("rst_ready", a_ready, 1);
        chk("rst_pt", a_pt, 0);
        chk("rst_key", a_key, 0);
        chk("rst_start", a_start, 0);
        chk("rst_dvalid", a_dvalid, 0);
        chk("rst_edone", a_edone, 0);
        chk("rst_err", a_err, 0);

        for (int i = 0; i < 34; i++) begin
            a_cmd = tv[i].cmd;
            a_din = tv[i].din;
            tick();
            chk($sformatf("load_pt[%0d]", i), a_pt, tv[i].exp_pt);
            chk($sformatf("load_key[%0d]", i), a_key, tv[i].exp_key);
        end
        a_cmd = C_ID;
        tick();

        // start held for 9 cycles
        a_cmd  = C_ST;
        starts = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            starts += int'(a_start);
            if (k == 0) chk("start_pulse", a_start, 1);
            chk("start_ready_low", a_ready, 0);
        end
        chk("start_count", starts, 1);
        chk("start_err", a_err, 0);
        a_cmd = C_ID;

        // drain with dout_ready high
        a_cdone = 1'b1;
        tick();
        a_cdone  = 1'b0;
        a_dready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_valid[%0d]", i), a_dvalid, 1);
            chk($sformatf("drain_dout[%0d]", i), a_dout, ct_v[127-8*i -: 8]);
            chk($sformatf("drain_edone[%0d]", i), a_edone, 0);
            tick();
        end
        chk("drain_edone", a_edone, 1);
        chk("drain_ready", a_ready, 1);
        chk("drain_dvalid_end", a_dvalid, 0);
        a_dready = 1'b0;
        tick();
        chk("drain_edone_pulse", a_edone, 0);

        // short plaintext then start: refused
        load_a(C_SP, PT2, 10);
        a_cmd = C_ST;
        tick();
        chk("short_start", a_start, 0);
        chk("short_err", a_err, 1);
        chk("short_ready", a_ready, 1);

        // new plaintext, key reused
        a_cmd = C_ID;
        tick();
        load_a(C_SP, PT2, 16);
        chk("pt2", a_pt, PT2);
        chk("pt2_key_kept", a_key, KEY);
        a_cmd = C_ST;
        tick();
        chk("reuse_start", a_start, 1);
        chk("reuse_err_clr", a_err, 0);
        a_cmd = C_ID;

        // drain with dout_ready toggling
        a_cdone = 1'b1;
        tick();
        a_cdone = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 64 && idx < 16; cyc++) begin
            rdy = (cyc % 2 == 0);
            a_dready = rdy;
            chk($sformatf("toggle_dout[%0d]", cyc), a_dout, ct_v[127-8*idx -: 8]);
            tick();
            if (rdy) idx++;
        end
        chk("toggle_beats", idx, 16);
        chk("toggle_edone", a_edone, 1);
        a_dready = 1'b0;
        tick();

        // start with no fresh plaintext
        a_cmd = C_ST;
        tick();
        chk("nopt_start", a_start, 0);
        chk("nopt_err", a_err, 1);
        a_cmd = C_ID;
        tick();

        // wide instance
        for (int i = 0; i < 4; i++) begin
            b_cmd = C_SP;
            b_din = PT[127-32*i -: 32];
            tick();
        end
        chk("wide_pt", b_pt, PT);
        b_cmd = C_ID;
        tick();
        for (int i = 0; i < 8; i++) begin
            b_cmd = C_SK;
            b_din = k_v[255-32*i -: 32];
            tick();
        end
        chk("wide_key", b_key, KEY256);
        b_cmd = C_ST;
        tick();
        chk("wide_start", b_start, 1);
        chk("wide_busy", b_ready, 0);
        b_cmd = C_ID;
        tick();
        rst_ = 1'b1;
        tick();
        rst_ = 1'b0;
        chk("wide_rst_ready", b_ready, 1);
        chk("wide_rst_pt", b_pt, 0);
        chk("wide_rst_key", b_key, 0);
        chk("wide_rst_start", b_start, 0);
        chk("wide_rst_err", b_err, 0);
        chk("wide_rst_dvalid", b_dvalid, 0);
        b_cdone = 1'b1;
        tick();
        b_cdone = 1'b0;
        chk("wide_done_ignored", b_dvalid, 0);
        chk("wide_done_dout", b_dout, 0);
        tick();
        chk("wide_done_ignored2", b_dvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
